// File: rtl/fpu_share_sched_if.sv
// Request/response and FPU-side signal bundle for fpu_share_sched.
// slave: the scheduler; master: clients plus the FPU top level.
interface fpu_share_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_data;
    logic [31:0] fpu_a;
    logic [31:0] fpu_b;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_result;
    logic        busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, fpu_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data,
        output fpu_a, fpu_b, fpu_op, busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, fpu_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data,
        input  fpu_a, fpu_b, fpu_op, busy
    );
endinterface

// File: rtl/fpu_share_sched.sv
// Time-shares one FPU between two clients, one operation in flight.
// Define FPU_SCHED_RR_EN for round-robin; default is fixed priority.
module fpu_share_sched #(
    parameter int LAT_ADD = 3,
    parameter int LAT_SUB = 3,
    parameter int LAT_MUL = 4,
    parameter int LAT_DIV = 16,
    parameter int CNT_W   = 5
) (
    input logic               clk,
    input logic               rst_n,
    fpu_share_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_lat;
    logic               r_id;
    logic [31:0]        r_fpu_a;
    logic [31:0]        r_fpu_b;
    logic [1:0]         r_fpu_op;
    logic [31:0]        r_rsp_data;
    logic               w_gnt;
    logic               w_gnt_vld;
    logic               w_acc;
    logic               w_cap;
    logic               w_rsp_rdy;
    logic [1:0]         w_sel_op;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;

`ifdef FPU_SCHED_RR_EN
    logic               r_last;

    always_comb begin
        w_gnt_vld = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid & bus.req1_valid)
            w_gnt = ~r_last;
        else
            w_gnt = bus.req1_valid;
    end
`else
    always_comb begin
        w_gnt_vld = bus.req0_valid | bus.req1_valid;
        w_gnt     = ~bus.req0_valid;
    end
`endif

    assign w_sel_op = w_gnt ? bus.req1_op : bus.req0_op;
    assign w_sel_a  = w_gnt ? bus.req1_a  : bus.req0_a;
    assign w_sel_b  = w_gnt ? bus.req1_b  : bus.req0_b;
    assign w_rsp_rdy = r_id ? bus.rsp1_ready : bus.rsp0_ready;

    always_comb begin
        w_lat = CNT_W'(LAT_ADD);
        unique case (w_sel_op)
            2'd0: w_lat = CNT_W'(LAT_ADD);
            2'd1: w_lat = CNT_W'(LAT_SUB);
            2'd2: w_lat = CNT_W'(LAT_MUL);
            2'd3: w_lat = CNT_W'(LAT_DIV);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc       = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_acc       = 1'b1;
                    w_cnt_nxt   = w_lat;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                // result is valid on the last cycle of the count
                if (r_cnt == CNT_W'(1)) begin
                    w_cap       = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (w_rsp_rdy)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_id       <= 1'b0;
            r_fpu_a    <= '0;
            r_fpu_b    <= '0;
            r_fpu_op   <= '0;
            r_rsp_data <= '0;
`ifdef FPU_SCHED_RR_EN
            r_last     <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_acc) begin
                r_id     <= w_gnt;
                r_fpu_a  <= w_sel_a;
                r_fpu_b  <= w_sel_b;
                r_fpu_op <= w_sel_op;
`ifdef FPU_SCHED_RR_EN
                r_last   <= w_gnt;
`endif
            end
            if (w_cap)
                r_rsp_data <= bus.fpu_result;
        end
    end

    assign bus.req0_ready = (r_state == IDLE) & w_gnt_vld & ~w_gnt;
    assign bus.req1_ready = (r_state == IDLE) & w_gnt_vld & w_gnt;
    assign bus.rsp0_valid = (r_state == RESP) & ~r_id;
    assign bus.rsp1_valid = (r_state == RESP) & r_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.fpu_a      = r_fpu_a;
    assign bus.fpu_b      = r_fpu_b;
    assign bus.fpu_op     = r_fpu_op;
    assign bus.busy       = (r_state != IDLE);

endmodule

// File: doc/fpu_share_sched.md
# fpu_share_sched

Two-requester scheduler that time-shares the single-issue floating-point unit (add/sub/mul/div, 2-bit opcode, fixed pipeline latency per operation) between two clients. It arbitrates valid/ready requests, drives and holds the FPU operands and opcode for the operation's latency, captures the result, and returns it to the originating client over a valid/ready response channel. It sits between the two consumers and the FPU top level. Only one operation is in flight at a time.

## Interface
- LAT_ADD, 3: cycles from operands stable to valid result for opcode 0 (add); legal range ≥1.
- LAT_SUB, 3: same, for opcode 1 (subtract).
- LAT_MUL, 4: same, for opcode 2 (multiply).
- LAT_DIV, 16: same, for opcode 3 (divide).
- CNT_W, 5: latency counter width; it must hold the largest LAT_*.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  request from client 0/1.
- req0_ready / req1_ready  out  1  request accepted this cycle when high together with the matching valid.
- req0_op / req1_op  in  2  opcode: 0 add, 1 sub, 2 mul, 3 div.
- req0_a / req1_a, req0_b / req1_b  in  32  IEEE-754 single-precision operands.
- rsp0_valid / rsp1_valid  out  1  result available for client 0/1.
- rsp0_ready / rsp1_ready  in  1  client takes the result.
- rsp_data  out  32  result word; meaningful only while either rsp valid is high.
- fpu_a, fpu_b  out  32  registered operands to the FPU.
- fpu_op  out  2  registered opcode to the FPU.
- fpu_result  in  32  FPU result bus.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Compute the grant from req*_valid.
  - reqN_ready = (state==IDLE) & (grant==N); ready is combinational from the valids.
  - On a handshake, register fpu_a, fpu_b and fpu_op from the winner.
  - Record the winner's id and load cnt = LAT_<op>.
  - Go to WAIT.
- WAIT:
  - fpu_a, fpu_b and fpu_op are held stable.
  - cnt decrements every cycle.
  - On the edge where cnt==1: capture fpu_result into rsp_data, go to RESP.
- RESP:
  - rspN_valid=1 for the recorded id only; rsp_data is held.
  - On rspN_valid & rspN_ready, clear valid and go to IDLE.
  - The other client's rsp_ready is ignored.
- No new request is accepted in the RESP cycle that completes the handshake. The next accept occurs in IDLE, at the earliest one cycle later.
- Arithmetic: no operand inspection. NaN, Inf and divide-by-zero results pass through unchanged.
- Request inputs are sampled only at the accept edge. Later changes do not affect the in-flight operation.

## Timing
- Reset values:
  - state IDLE, cnt 0, busy 0.
  - req0_ready and req1_ready follow the combinational grant rule (state is IDLE).
  - rsp0_valid 0, rsp1_valid 0, rsp_data 0.
  - fpu_a 0, fpu_b 0, fpu_op 0.
  - last_grant 1, so client 0 wins first.
- Accept at cycle T:
  - fpu_* are valid in cycles T+1 … T+LAT.
  - rsp valid rises in cycle T+LAT+1.
- Minimum accept-to-accept spacing is LAT+2 cycles, with rsp_ready held high.
- rsp_ready low holds RESP indefinitely. rsp_data and valid stay stable.
- Simultaneous valid on both clients in IDLE: resolved by the arbitration policy below.
- Reset asserted in WAIT or RESP takes effect on the next edge:
  - The in-flight operation is discarded.
  - No response is produced.
  - All outputs return to their reset values.
  - A late FPU result is ignored.

## Configuration
- FPU_SCHED_RR_EN defined: round-robin arbitration.
  - When both clients are valid, grant the client that is not last_grant.
  - When one client is valid, grant it.
  - last_grant updates on every accept.
- FPU_SCHED_RR_EN undefined: fixed priority, client 0 always wins when valid.
  - last_grant is not implemented.

## Test plan
- Single add from client 0, a=0x3F800000 (1.0), b=0x40000000 (2.0), op 0, rsp0_ready=1, accept at cycle 0:
  - fpu_op=0 during cycles 1–3.
  - rsp0_valid only in cycle 4, rsp_data=0x40400000.
  - rsp1_valid stays 0.
- Divide from client 1 with LAT_DIV=16, accept at cycle 0: busy=1 in cycles 1–17, rsp1_valid rises in cycle 17.
- Both clients valid every cycle (RR_EN defined): grants alternate 0,1,0,1. With the macro undefined, all grants go to client 0 while it is valid.
- Back-pressure: rsp0_ready=0 for 10 cycles in RESP:
  - rsp0_valid and rsp_data stay stable.
  - req*_ready stays 0.
  - After ready rises, IDLE is entered on the next cycle and an accept follows.
- Request operands change during WAIT: fpu_a, fpu_b and fpu_op stay at the accepted values.
- rst_n pulled low for 1 cycle mid-WAIT:
  - Next cycle: busy=0, fpu_*=0, no rsp valid.
  - The following request is granted to client 0.
